training_sequencer: RTL and testbench

// Upstream stage of the perceptron: holds a small training set and replays it as x/expected_y/train/learning_rate.

---
 rtl/training_sequencer_if.sv | 36 +++
 rtl/training_sequencer.sv | 158 +++++++++++++++
 tb/tb_training_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/training_sequencer_if.sv
// Bus between the perceptron training sequencer and its environment.
// The master side loads samples, starts runs and returns y. The slave side is the sequencer.
interface training_sequencer_if #(
  parameter int N  = 8,
  parameter int AW = 4
);
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [N-2:0]      wr_x;
  logic [31:0]       wr_y;
  logic [AW:0]       n_samples;
  logic [15:0]       max_epochs;
  logic [31:0]       lr_in;
  logic              start;
  logic              abort;
  logic [31:0]       y;
  logic [N-2:0]      x;
  logic [31:0]       expected_y;
  logic              train;
  logic [31:0]       learning_rate;
  logic              busy;
  logic              done;
  logic              converged;
  logic [15:0]       epoch_count;
  logic [AW:0]       err_count;

  modport master (
    output wr_en, wr_addr, wr_x, wr_y, n_samples, max_epochs, lr_in, start, abort, y,
    input  x, expected_y, train, learning_rate, busy, done, converged, epoch_count, err_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_y, n_samples, max_epochs, lr_in, start, abort, y,
    output x, expected_y, train, learning_rate, busy, done, converged, epoch_count, err_count
  );
endinterface

// File: rtl/training_sequencer.sv
// Replays a stored training set to a perceptron, epoch by epoch, spacing samples by GAP idle
// cycles and counting sign misclassifications until a clean epoch or the epoch limit.
//   state       | meaning
//   S_IDLE      | waiting for start; sample memory writable
//   S_PRESENT   | one cycle, x/expected_y shown with train=1
//   S_GAP       | GAP cycles of train=0 while the weight update settles
//   S_EPOCH_END | publish error count, bump epoch, decide stop or next epoch
//   S_DONE      | one cycle, done pulses on the way back to idle
module training_sequencer #(
  parameter int N     = 8,
  parameter int AW    = 4,
  parameter int GAP   = 3,
  parameter int Y_LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  training_sequencer_if.slave bus
);
  localparam int DEPTH = 2**AW;
  localparam int CW    = AW + 1;
  localparam int PW    = $clog2(GAP + 2);
  localparam logic [CW-1:0] ERR_MAX = {CW{1'b1}};
  localparam logic [PW-1:0] GAP_LD  = PW'(GAP);
  localparam logic [PW-1:0] Y_TAP   = PW'(GAP + 1 - Y_LAT);
  localparam logic [AW-1:0] IDX0    = '0;

  typedef enum logic [2:0] {S_IDLE, S_PRESENT, S_GAP, S_EPOCH_END, S_DONE} state_t;

  state_t        state_q;
  logic [N-2:0]  mem_x [DEPTH];
  logic [31:0]   mem_y [DEPTH];
  logic [AW-1:0] idx_q;
  logic [PW-1:0] gap_q;
  logic [CW-1:0] n_q, run_q, err_q;
  logic [15:0]   max_q, epoch_q;
  logic [31:0]   lr_q, exp_q;
  logic [N-2:0]  x_q;
  logic          train_q, busy_q, done_q, conv_q;

  logic          wr_ok, fwd0, y_hit, y_err, last_sample;
  logic [AW-1:0] idx_nx;

  assign wr_ok       = bus.wr_en && (state_q == S_IDLE || state_q == S_DONE);
  // A write to address 0 in the start cycle must be seen by the first presentation.
  assign fwd0        = wr_ok && (bus.wr_addr == IDX0);
  assign idx_nx      = idx_q + AW'(1);
  assign last_sample = ({1'b0, idx_q} + CW'(1)) >= n_q;
  assign y_hit       = (Y_LAT == 0) ? (state_q == S_PRESENT)
                                    : (state_q == S_GAP && gap_q == Y_TAP);
  assign y_err       = bus.y[31] != exp_q[31];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_x[bus.wr_addr] <= bus.wr_x;
      mem_y[bus.wr_addr] <= bus.wr_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      n_q     <= '0;
      max_q   <= '0;
      lr_q    <= '0;
      x_q     <= '0;
      exp_q   <= '0;
      train_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      epoch_q <= '0;
      run_q   <= '0;
      err_q   <= '0;
    end else begin
      train_q <= 1'b0;
      done_q  <= 1'b0;
      if (y_hit && y_err && run_q != ERR_MAX) run_q <= run_q + CW'(1);
      if (bus.abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (bus.start) begin
            n_q     <= bus.n_samples;
            max_q   <= bus.max_epochs;
            lr_q    <= bus.lr_in;
            epoch_q <= '0;
            conv_q  <= 1'b0;
            run_q   <= '0;
            idx_q   <= '0;
            if (bus.n_samples == '0 || bus.max_epochs == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_PRESENT;
              busy_q  <= 1'b1;
              train_q <= 1'b1;
              x_q     <= fwd0 ? bus.wr_x : mem_x[IDX0];
              exp_q   <= fwd0 ? bus.wr_y : mem_y[IDX0];
            end
          end
          S_PRESENT: begin
            state_q <= S_GAP;
            gap_q   <= GAP_LD;
          end
          S_GAP: if (gap_q == PW'(1)) begin
            if (last_sample) begin
              state_q <= S_EPOCH_END;
            end else begin
              state_q <= S_PRESENT;
              idx_q   <= idx_nx;
              train_q <= 1'b1;
              x_q     <= mem_x[idx_nx];
              exp_q   <= mem_y[idx_nx];
            end
          end else begin
            gap_q <= gap_q - PW'(1);
          end
          S_EPOCH_END: begin
            err_q   <= run_q;
            epoch_q <= epoch_q + 16'd1;
            run_q   <= '0;
            if (run_q == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              conv_q  <= 1'b1;
            end else if (epoch_q + 16'd1 == max_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_PRESENT;
              idx_q   <= '0;
              train_q <= 1'b1;
              x_q     <= mem_x[IDX0];
              exp_q   <= mem_y[IDX0];
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.x             = x_q;
  assign bus.expected_y    = exp_q;
  assign bus.train         = train_q;
  assign bus.learning_rate = lr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.converged     = conv_q;
  assign bus.epoch_count   = epoch_q;
  assign bus.err_count     = err_q;
endmodule

// File: tb/tb_training_sequencer.sv
// Bench for training_sequencer: drives y from a behavioural environment (sign-matching, sign-wrong,
// random or a small delayed-update perceptron) and checks every presentation and run result.
module tb_training_sequencer;
  localparam int N = 8, AW = 4, GAP = 3, DEPTH = 16, CW = AW + 1;
  localparam int M_MATCH = 0, M_WRONG = 1, M_RAND = 2, M_PERC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  training_sequencer_if #(.N(N), .AW(AW)) bus ();
  training_sequencer #(.N(N), .AW(AW), .GAP(GAP), .Y_LAT(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, mode = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  logic [N-2:0] m_x [DEPTH];
  logic [31:0]  m_y [DEPTH];
  int           pulse_cyc [$];
  logic [N-2:0] pulse_x [$];
  logic [31:0]  pulse_exp [$];
  logic [31:0]  pulse_y [$];
  int w0, w1, w2, pend, dw;
  logic [1:0] pend_x;

  always @(posedge clk) cyc++;

  // Environment: y for the current presentation, plus a perceptron whose weights land 3 cycles late.
  always @(negedge clk) begin
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        w0 += dw;
        if (pend_x[0]) w1 += dw;
        if (pend_x[1]) w2 += dw;
      end
    end
    case (mode)
      M_MATCH: bus.y = {bus.expected_y[31], 31'($urandom)};
      M_WRONG: bus.y = {~bus.expected_y[31], 31'($urandom)};
      M_RAND:  bus.y = $urandom;
      default: bus.y = 32'(w0 + (bus.x[0] ? w1 : 0) + (bus.x[1] ? w2 : 0));
    endcase
    if (bus.train) begin
      pulse_cyc.push_back(cyc);
      pulse_x.push_back(bus.x);
      pulse_exp.push_back(bus.expected_y);
      pulse_y.push_back(bus.y);
      if (mode == M_PERC && bus.y[31] != bus.expected_y[31]) begin
        pend   = 3;
        pend_x = bus.x[1:0];
        dw     = bus.expected_y[31] ? -int'($signed(bus.learning_rate)) : int'($signed(bus.learning_rate));
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic wr(input int a, input logic [N-2:0] xv, input logic [31:0] yv);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_x = xv; bus.wr_y = yv;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    m_x[a] = xv; m_y[a] = yv;
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++) wr(i, 7'($urandom), $urandom);
  endtask

  task automatic load_and();
    for (int i = 0; i < 4; i++) wr(i, 7'(i), (i == 3) ? 32'h0001_0000 : 32'hFFFF_0000);
  endtask

  task automatic kick(input int n, input int mx, input logic [31:0] lr, input int md);
    @(negedge clk);
    mode = md;
    pulse_cyc.delete(); pulse_x.delete(); pulse_exp.delete(); pulse_y.delete();
    done_cnt = 0; w0 = 0; w1 = 0; w2 = 0; pend = 0;
    bus.n_samples = CW'(n); bus.max_epochs = 16'(mx); bus.lr_in = lr; bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin to = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  // Spec-level reference: group the presentations into epochs and apply the stop rule.
  task automatic model_eval(input int n, input int mx, output int e_ep, output int e_err);
    int errs, k;
    e_ep = 0; e_err = 0;
    for (int e = 1; e <= mx; e++) begin
      errs = 0;
      for (int i = 0; i < n; i++) begin
        k = (e - 1) * n + i;
        if (k >= pulse_y.size() || pulse_y[k][31] != m_y[i][31]) errs++;
      end
      e_ep = e; e_err = errs;
      if (errs == 0) break;
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_x = 0; bus.wr_y = 0; bus.n_samples = 0;
    bus.max_epochs = 0; bus.lr_in = 0; bus.start = 0; bus.abort = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.x, bus.expected_y, bus.train, bus.learning_rate, bus.busy, bus.done,
         bus.converged, bus.epoch_count, bus.err_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b train=%b done=%b conv=%b epoch=%0d err=%0d x=%h exp=%h lr=%h required all zero",
               bus.busy, bus.train, bus.done, bus.converged, bus.epoch_count, bus.err_count,
               bus.x, bus.expected_y, bus.learning_rate);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_runs();
    int n, mx, md, ep, er, budget, lim, gap_exp;
    logic [31:0] lr;
    bit to;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin load_random(); n = 4; mx = 10; md = M_MATCH; lr = $urandom; end
        1: begin n = 3; mx = 5; md = M_WRONG; lr = $urandom; end
        5: begin load_and(); n = 4; mx = 20; md = M_PERC; lr = 32'h0001_0000; end
        default: begin
          load_random(); n = $urandom_range(16, 1); mx = $urandom_range(4, 1);
          md = M_RAND; lr = $urandom;
        end
      endcase
      budget = mx * (n * (1 + GAP) + 1) + 20;
      kick(n, mx, lr, md);
      wait_done(budget, to);
      model_eval(n, mx, ep, er);
      checks++;
      if (to) begin failures++; $display("FAIL run%0d_done_timeout got no done within %0d cycles", s, budget); end
      checks++;
      if (pulse_x.size() != ep * n) begin
        failures++; $display("FAIL run%0d_pulse_count got=%0d required=%0d", s, pulse_x.size(), ep * n);
      end
      lim = (pulse_x.size() < ep * n) ? pulse_x.size() : ep * n;
      for (int k = 0; k < lim; k++) begin
        checks++;
        if (pulse_x[k] !== m_x[k % n] || pulse_exp[k] !== m_y[k % n]) begin
          failures++;
          $display("FAIL run%0d_sample%0d got x=%h y=%h required x=%h y=%h", s, k,
                   pulse_x[k], pulse_exp[k], m_x[k % n], m_y[k % n]);
        end
        if (k > 0) begin
          gap_exp = (k % n == 0) ? GAP + 2 : GAP + 1;
          checks++;
          if (pulse_cyc[k] - pulse_cyc[k-1] != gap_exp) begin
            failures++;
            $display("FAIL run%0d_spacing%0d got=%0d required=%0d", s, k, pulse_cyc[k] - pulse_cyc[k-1], gap_exp);
          end
        end
      end
      if (lim > 0) begin
        checks++;
        if (pulse_cyc[0] - start_cyc != 1) begin
          failures++; $display("FAIL run%0d_first_latency got=%0d required=1", s, pulse_cyc[0] - start_cyc);
        end
        checks++;
        if (done_cyc - pulse_cyc[lim-1] != GAP + 3) begin
          failures++; $display("FAIL run%0d_done_latency got=%0d required=%0d", s, done_cyc - pulse_cyc[lim-1], GAP + 3);
        end
      end
      checks++;
      if (bus.epoch_count !== 16'(ep)) begin
        failures++; $display("FAIL run%0d_epoch_count got=%0d required=%0d", s, bus.epoch_count, ep);
      end
      checks++;
      if (bus.err_count !== CW'(er)) begin
        failures++; $display("FAIL run%0d_err_count got=%0d required=%0d", s, bus.err_count, er);
      end
      checks++;
      if (bus.converged !== (er == 0)) begin
        failures++; $display("FAIL run%0d_converged got=%b required=%b", s, bus.converged, er == 0);
      end
      checks++;
      if (bus.learning_rate !== lr || bus.busy !== 1'b0 || done_cnt != 1) begin
        failures++;
        $display("FAIL run%0d_status got lr=%h busy=%b dones=%0d required lr=%h busy=0 dones=1", s,
                 bus.learning_rate, bus.busy, done_cnt, lr);
      end
      if (s == 0) begin
        checks++;
        if (bus.epoch_count !== 16'd1 || bus.converged !== 1'b1 || bus.err_count !== '0 || pulse_x.size() != 4) begin
          failures++;
          $display("FAIL match_run got epoch=%0d conv=%b err=%0d pulses=%0d required 1 1 0 4",
                   bus.epoch_count, bus.converged, bus.err_count, pulse_x.size());
        end
      end
      if (s == 1) begin
        checks++;
        if (bus.epoch_count !== 16'd5 || bus.converged !== 1'b0 || bus.err_count !== CW'(3) || pulse_x.size() != 15) begin
          failures++;
          $display("FAIL wrong_run got epoch=%0d conv=%b err=%0d pulses=%0d required 5 0 3 15",
                   bus.epoch_count, bus.converged, bus.err_count, pulse_x.size());
        end
      end
      if (s == 5) begin
        checks++;
        if (bus.converged !== 1'b1 || bus.epoch_count > 16'd20) begin
          failures++; $display("FAIL and_learning got conv=%b epoch=%0d required conv=1 within 20", bus.converged, bus.epoch_count);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    bit to;
    kick(2, 3, 32'h55, M_MATCH);
    wait_done(60, to);
    checks++;
    if (to || bus.converged !== 1'b1) begin
      failures++; $display("FAIL zero_pre_run got timeout=%0d conv=%b required 0 1", to, bus.converged);
    end
    for (int c = 0; c < 2; c++) begin
      if (c == 0) kick(0, 5, 32'h66, M_MATCH); else kick(3, 0, 32'h77, M_MATCH);
      wait_done(20, to);
      checks++;
      if (to || done_cyc - start_cyc != 2) begin
        failures++; $display("FAIL zero%0d_done_latency got timeout=%0d latency=%0d required 2", c, to, done_cyc - start_cyc);
      end
      checks++;
      if (pulse_x.size() != 0 || bus.converged !== 1'b0 || bus.epoch_count !== 16'd0 || done_cnt != 1) begin
        failures++;
        $display("FAIL zero%0d_result got pulses=%0d conv=%b epoch=%0d dones=%0d required 0 0 0 1", c,
                 pulse_x.size(), bus.converged, bus.epoch_count, done_cnt);
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit to;
    kick(4, 3, 32'hABCD, M_WRONG);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.n_samples = CW'(1); bus.max_epochs = 16'd1; bus.lr_in = 32'h1111;
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_x = ~m_x[0]; bus.wr_y = ~m_y[0];
    @(posedge clk);
    #1 bus.start = 1'b0; bus.wr_en = 1'b0;
    wait_done(100, to);
    checks++;
    if (to || pulse_x.size() != 12) begin
      failures++; $display("FAIL busy_pulses got timeout=%0d pulses=%0d required 0 12", to, pulse_x.size());
    end
    for (int k = 0; k < pulse_x.size() && k < 12; k++) begin
      checks++;
      if (pulse_x[k] !== m_x[k % 4] || pulse_exp[k] !== m_y[k % 4]) begin
        failures++; $display("FAIL busy_sample%0d got x=%h required x=%h", k, pulse_x[k], m_x[k % 4]);
      end
    end
    checks++;
    if (bus.epoch_count !== 16'd3 || bus.err_count !== CW'(4) || bus.converged !== 1'b0 || bus.learning_rate !== 32'hABCD) begin
      failures++;
      $display("FAIL busy_result got epoch=%0d err=%0d conv=%b lr=%h required 3 4 0 abcd",
               bus.epoch_count, bus.err_count, bus.converged, bus.learning_rate);
    end
    kick(1, 1, 32'h1, M_MATCH);
    wait_done(30, to);
    checks++;
    if (to || pulse_x.size() != 1 || pulse_x[0] !== m_x[0] || pulse_exp[0] !== m_y[0]) begin
      failures++; $display("FAIL busy_mem_intact got pulses=%0d required x=%h y=%h", pulse_x.size(), m_x[0], m_y[0]);
    end
  endtask

  task automatic test_abort();
    int c;
    kick(2, 10, 32'h42, M_WRONG);
    for (int i = 0; i < 20 && pulse_cyc.size() == 0; i++) @(negedge clk);
    checks++;
    if (pulse_cyc.size() == 0) begin
      failures++; $display("FAIL abort_first_pulse got none required one"); return;
    end
    c = pulse_cyc[0];
    for (int i = 0; i < 40 && cyc != c + 17; i++) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.train !== 1'b0 || bus.epoch_count !== 16'd1) begin
      failures++;
      $display("FAIL abort_epoch_end got busy=%b train=%b epoch=%0d required 0 0 1", bus.busy, bus.train, bus.epoch_count);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (pulse_x.size() != 4 || done_cnt != 0 || bus.err_count !== CW'(2)) begin
      failures++;
      $display("FAIL abort_after got pulses=%0d dones=%0d err=%0d required 4 0 2", pulse_x.size(), done_cnt, bus.err_count);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.n_samples = CW'(2); bus.max_epochs = 16'd10;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.abort = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || pulse_x.size() != 4 || done_cnt != 0) begin
      failures++;
      $display("FAIL abort_beats_start got busy=%b pulses=%0d dones=%0d required 0 4 0", bus.busy, pulse_x.size(), done_cnt);
    end
  endtask

  task automatic test_write_start_same();
    logic [N-2:0] nx;
    logic [31:0] ny;
    bit to;
    nx = m_x[0] ^ 7'h55;
    ny = ~m_y[0];
    @(negedge clk);
    mode = M_MATCH;
    pulse_cyc.delete(); pulse_x.delete(); pulse_exp.delete(); pulse_y.delete();
    done_cnt = 0;
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_x = nx; bus.wr_y = ny;
    bus.n_samples = CW'(1); bus.max_epochs = 16'd1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.wr_en = 1'b0; bus.start = 1'b0;
    m_x[0] = nx; m_y[0] = ny;
    wait_done(30, to);
    checks++;
    if (to || pulse_x.size() != 1 || pulse_x[0] !== nx || pulse_exp[0] !== ny || bus.converged !== 1'b1) begin
      failures++;
      $display("FAIL write_then_start got pulses=%0d conv=%b required x=%h y=%h conv=1", pulse_x.size(), bus.converged, nx, ny);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int e_ep, e_err;
    kick(4, 10, 32'h9999, M_WRONG);
    for (int i = 0; i < 20 && pulse_cyc.size() == 0; i++) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.x, bus.expected_y, bus.train, bus.learning_rate, bus.busy, bus.done,
         bus.converged, bus.epoch_count, bus.err_count} !== '0) begin
      failures++;
      $display("FAIL reset_mid_run busy=%b train=%b lr=%h x=%h exp=%h required all zero",
               bus.busy, bus.train, bus.learning_rate, bus.x, bus.expected_y);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    kick(4, 10, 32'h3, M_MATCH);
    wait_done(60, to);
    model_eval(4, 10, e_ep, e_err);
    checks++;
    if (to || pulse_x.size() != 4 || bus.converged !== 1'b1 || e_ep != 1) begin
      failures++; $display("FAIL reset_rerun got pulses=%0d conv=%b required 4 1", pulse_x.size(), bus.converged);
    end
    for (int k = 0; k < pulse_x.size() && k < 4; k++) begin
      checks++;
      if (pulse_x[k] !== m_x[k] || pulse_exp[k] !== m_y[k]) begin
        failures++; $display("FAIL reset_mem%0d got x=%h y=%h required x=%h y=%h", k, pulse_x[k], pulse_exp[k], m_x[k], m_y[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_runs();
    test_zero_len();
    test_busy_ignore();
    test_abort();
    test_write_start_same();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
